// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the integer ALU and the two-port ALU arbiter.
//   - ALU_W        : datapath width of the integer ALU (fixed at 32)
//   - alu_op_t     : 4-bit opcode encodings of the ten legal operations
//   - arb_state_t  : arbiter FSM state encoding
//   - alu_op_legal : 1 when an opcode is one of the legal encodings
package alu_pkg;

    localparam int ALU_W = 32;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SLL  = 4'b0001,
        ALU_SLT  = 4'b0010,
        ALU_SLTU = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_OR   = 4'b0110,
        ALU_AND  = 4'b0111,
        ALU_SUB  = 4'b1000,
        ALU_SRA  = 4'b1101
    } alu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } arb_state_t;

    function automatic logic alu_op_legal(input logic [3:0] op);
        logic legal;
        case (op)
            ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
            ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND: legal = 1'b1;
            default:                                    legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/alu.sv
// alu: purely combinational 32-bit integer ALU.
// Ports:
//   alu_op     in  4      opcode (alu_pkg::alu_op_t encodings)
//   operand1   in  ALU_W  first operand
//   operand2   in  ALU_W  second operand (shifts use bits [4:0] only)
//   alu_result out ALU_W  result; 0 for any illegal opcode
module alu
    import alu_pkg::*;
(
    input  logic [3:0]       alu_op,
    input  logic [ALU_W-1:0] operand1,
    input  logic [ALU_W-1:0] operand2,
    output logic [ALU_W-1:0] alu_result
);

    logic [4:0] shamt;
    logic       lt_signed;
    logic       lt_unsigned;

    always_comb begin
        shamt       = operand2[4:0];
        lt_signed   = $signed(operand1) < $signed(operand2);
        lt_unsigned = operand1 < operand2;
        alu_result  = '0;
        case (alu_op)
            ALU_ADD:  alu_result = operand1 + operand2;
            ALU_SUB:  alu_result = operand1 - operand2;
            ALU_SLL:  alu_result = operand1 << shamt;
            ALU_SLT:  alu_result = {{(ALU_W-1){1'b0}}, lt_signed};
            ALU_SLTU: alu_result = {{(ALU_W-1){1'b0}}, lt_unsigned};
            ALU_XOR:  alu_result = operand1 ^ operand2;
            ALU_SRL:  alu_result = operand1 >> shamt;
            ALU_SRA:  alu_result = $signed(operand1) >>> shamt;
            ALU_OR:   alu_result = operand1 | operand2;
            ALU_AND:  alu_result = operand1 & operand2;
            default:  alu_result = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational alu between two requesters.
// Round-robin arbitration in IDLE, one cycle of ALU evaluation in EXEC,
// result held on the owner's response channel in RESP. One op in flight.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   reqN_valid / reqN_ready       request handshake (N = 0, 1)
//   reqN_op, reqN_a, reqN_b       opcode and operands
//   reqN_tag                      opaque tag echoed on the response
//   rspN_valid / rspN_ready       response handshake
//   rspN_result, rspN_tag         ALU result and echoed tag
//   rspN_illegal                  opcode was illegal (result forced to 0)
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1; the producer holds its payload stable while valid=1 and ready=0,
// and reqN_ready never waits on anything but arbitration and FSM state.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [3:0]        req0_op,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [TAG_W-1:0]  req0_tag,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [3:0]        req1_op,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [TAG_W-1:0]  req1_tag,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [DATA_W-1:0] rsp0_result,
    output logic [TAG_W-1:0]  rsp0_tag,
    output logic              rsp0_illegal,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp1_result,
    output logic [TAG_W-1:0]  rsp1_tag,
    output logic              rsp1_illegal
);

    arb_state_t        state_q,   state_d;
    logic              prio_q,    prio_d;
    logic              owner_q,   owner_d;
    logic [3:0]        op_q,      op_d;
    logic [DATA_W-1:0] a_q,       a_d;
    logic [DATA_W-1:0] b_q,       b_d;
    logic [TAG_W-1:0]  tag_q,     tag_d;
    logic [DATA_W-1:0] result_q,  result_d;
    logic              illegal_q, illegal_d;

    logic              grant_any;
    logic              grant_id;
    logic              owner_rsp_ready;
    logic [DATA_W-1:0] alu_result;

    alu u_alu (
        .alu_op     (op_q),
        .operand1   (a_q),
        .operand2   (b_q),
        .alu_result (alu_result)
    );

    // Round-robin: a lone requester always wins; on contention prio_q wins.
    always_comb begin
        grant_any = req0_valid || req1_valid;
        if (req0_valid && req1_valid) begin
            grant_id = prio_q;
        end else begin
            grant_id = req1_valid;
        end
    end

    // Gated by rst so both ready outputs are 0 for the whole reset pulse,
    // not only after the first reset edge.
    assign req0_ready = !rst && (state_q == ST_IDLE) && req0_valid && (grant_id == 1'b0);
    assign req1_ready = !rst && (state_q == ST_IDLE) && req1_valid && (grant_id == 1'b1);

    assign owner_rsp_ready = owner_q ? rsp1_ready : rsp0_ready;

    always_comb begin
        state_d   = state_q;
        prio_d    = prio_q;
        owner_d   = owner_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        tag_d     = tag_q;
        result_d  = result_q;
        illegal_d = illegal_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_any) begin
                    state_d = ST_EXEC;
                    owner_d = grant_id;
                    prio_d  = !grant_id;
                    op_d    = grant_id ? req1_op  : req0_op;
                    a_d     = grant_id ? req1_a   : req0_a;
                    b_d     = grant_id ? req1_b   : req0_b;
                    tag_d   = grant_id ? req1_tag : req0_tag;
                end
            end
            ST_EXEC: begin
                result_d  = alu_result;
                illegal_d = !alu_op_legal(op_q);
                state_d   = ST_RESP;
            end
            ST_RESP: begin
                // Only the owner's ready can release the result.
                if (owner_rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            prio_q    <= 1'b0;
            owner_q   <= 1'b0;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            tag_q     <= '0;
            result_q  <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            prio_q    <= prio_d;
            owner_q   <= owner_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            tag_q     <= tag_d;
            result_q  <= result_d;
            illegal_q <= illegal_d;
        end
    end

    assign rsp0_valid   = !rst && (state_q == ST_RESP) && (owner_q == 1'b0);
    assign rsp1_valid   = !rst && (state_q == ST_RESP) && (owner_q == 1'b1);
    assign rsp0_result  = result_q;
    assign rsp1_result  = result_q;
    assign rsp0_tag     = tag_q;
    assign rsp1_tag     = tag_q;
    assign rsp0_illegal = illegal_q;
    assign rsp1_illegal = illegal_q;

endmodule
